output_scaler_sequencer: RTL and testbench

//  Sequences the per-channel output-scaler datapath between the accumulator stream and the output writeback.

---
 rtl/output_scaler_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_output_scaler_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_scaler_sequencer.sv
// Output-scaler sequencer.
// Holds a per-channel quantisation table, walks channel/pixel counters over
// the accumulator stream, registers each beat together with its channel's
// parameters for an external combinational scaler, and captures the scaler
// result into a valid/ready output stage that tags the final beat of a run.
module output_scaler_sequencer #(
  parameter int NUM_CH_MAX     = 32,
  parameter int PX_W           = 16,
  parameter int inputWidth     = 20,
  parameter int maxOutputWidth = 8,
  parameter int fixedPointBits = 16,
  parameter int shiftBits      = 16,
  localparam int CH_W          = $clog2(NUM_CH_MAX) + 1,
  localparam int IDX_W         = CH_W - 1
) (
  input  logic                             clk,
  input  logic                             rst,
  // run control
  input  logic                             start_i,
  input  logic [CH_W-1:0]                  num_ch_i,
  input  logic [PX_W-1:0]                  num_px_i,
  input  logic                             cfg_unsigned_i,
  input  logic [3:0]                       cfg_obits_i,
  output logic                             busy_o,
  output logic                             done_o,
  // parameter table write port
  input  logic                             prm_we_i,
  input  logic [IDX_W-1:0]                 prm_addr_i,
  input  logic [fixedPointBits-1:0]        prm_scale_i,
  input  logic [shiftBits-1:0]             prm_shift_i,
  input  logic [maxOutputWidth-1:0]        prm_offset_i,
  input  logic [31:0]                      prm_bias_i,
  output logic                             prm_err_o,
  // accumulator stream
  input  logic                             acc_valid_i,
  output logic                             acc_ready_o,
  input  logic signed [inputWidth-1:0]     acc_data_i,
  // operands to / result from the external scaler
  output logic signed [inputWidth-1:0]     sc_wx_o,
  output logic [fixedPointBits-1:0]        sc_scale_o,
  output logic [shiftBits-1:0]             sc_shift_o,
  output logic [maxOutputWidth-1:0]        sc_offset_o,
  output logic [31:0]                      sc_bias_o,
  output logic                             sc_unsigned_o,
  output logic [3:0]                       sc_output_bits_o,
  input  logic [maxOutputWidth-1:0]        sc_y_i,
  // output stream
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [maxOutputWidth-1:0]        out_data_o,
  output logic [IDX_W-1:0]                 out_ch_o,
  output logic                             out_last_o,
  // observability
  output logic [1:0]                       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Parameter table
  logic [fixedPointBits-1:0] tbl_scale  [NUM_CH_MAX];
  logic [shiftBits-1:0]      tbl_shift  [NUM_CH_MAX];
  logic [maxOutputWidth-1:0] tbl_offset [NUM_CH_MAX];
  logic [31:0]               tbl_bias   [NUM_CH_MAX];

  // Run configuration and counters
  logic [CH_W-1:0]  num_ch_q;
  logic [PX_W-1:0]  num_px_q;
  logic             unsigned_q;
  logic [3:0]       obits_q;
  logic [IDX_W-1:0] ch_q;
  logic [PX_W-1:0]  px_q;

  // Pipeline stages: S1 = scaler operands, S2 = captured result
  logic             v1_q;
  logic [IDX_W-1:0] ch1_q;
  logic             last1_q;
  logic             v2_q;

  logic done_q;
  logic err_q;

  logic is_idle;
  logic start_ok;
  logic start_bad;
  logic addr_ok;
  logic prm_wr_ok;
  logic prm_reject;
  logic ch_last;
  logic px_last;
  logic beat_last;
  logic adv2;
  logic acc_accept;
  logic last_hs;

  assign is_idle    = (state_q == ST_IDLE);
  assign start_ok   = (num_ch_i != '0) && (num_px_i != '0) &&
                      (num_ch_i <= CH_W'(NUM_CH_MAX));
  assign start_bad  = is_idle & start_i & ~start_ok;
  assign addr_ok    = ({1'b0, prm_addr_i} < CH_W'(NUM_CH_MAX));
  assign prm_wr_ok  = prm_we_i & is_idle & addr_ok;
  assign prm_reject = prm_we_i & ~prm_wr_ok;

  assign ch_last    = ({1'b0, ch_q} == (num_ch_q - CH_W'(1)));
  assign px_last    = (px_q == (num_px_q - PX_W'(1)));
  assign beat_last  = ch_last & px_last;

  // Handshakes: a beat moves on a cycle where its valid and the consumer's
  // ready are both high at the clock edge. S2 takes S1 whenever S2 is empty
  // or is handing its beat downstream; S1 accepts a new beat whenever it is
  // empty or is moving into S2, so a full pipeline runs at one beat per cycle
  // and everything holds still while out_ready_i is low.
  assign adv2        = v1_q & (~v2_q | out_ready_i);
  assign acc_ready_o = (state_q == ST_RUN) & (~v1_q | adv2);
  assign acc_accept  = acc_valid_i & acc_ready_o;
  assign last_hs     = (state_q == ST_DRAIN) & v2_q & out_ready_i & out_last_o;

  assign busy_o           = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done_o           = done_q;
  assign prm_err_o        = err_q;
  assign out_valid_o      = v2_q;
  assign sc_unsigned_o    = unsigned_q;
  assign sc_output_bits_o = obits_q;
  assign dbg_state_o      = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: run until the last beat is accepted, drain until it leaves
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i && start_ok)         state_d = ST_RUN;
      ST_RUN:   if (acc_accept && beat_last)     state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs)                     state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // Parameter table: cleared on reset, written only from IDLE with an in-range index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH_MAX; i++) begin
        tbl_scale[i]  <= '0;
        tbl_shift[i]  <= '0;
        tbl_offset[i] <= '0;
        tbl_bias[i]   <= '0;
      end
    end else if (prm_wr_ok) begin
      tbl_scale[prm_addr_i]  <= prm_scale_i;
      tbl_shift[prm_addr_i]  <= prm_shift_i;
      tbl_offset[prm_addr_i] <= prm_offset_i;
      tbl_bias[prm_addr_i]   <= prm_bias_i;
    end
  end

  // Run configuration latch and channel/pixel walk
  always_ff @(posedge clk) begin
    if (rst) begin
      num_ch_q   <= '0;
      num_px_q   <= '0;
      unsigned_q <= 1'b0;
      obits_q    <= '0;
      ch_q       <= '0;
      px_q       <= '0;
    end else if (is_idle && start_i) begin
      num_ch_q   <= num_ch_i;
      num_px_q   <= num_px_i;
      unsigned_q <= cfg_unsigned_i;
      obits_q    <= cfg_obits_i;
      ch_q       <= '0;
      px_q       <= '0;
    end else if (acc_accept) begin
      if (ch_last) begin
        ch_q <= '0;
        px_q <= px_q + PX_W'(1);
      end else begin
        ch_q <= ch_q + IDX_W'(1);
      end
    end
  end

  // S1: accepted beat plus its channel's parameters, held for the scaler
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      ch1_q       <= '0;
      last1_q     <= 1'b0;
      sc_wx_o     <= '0;
      sc_scale_o  <= '0;
      sc_shift_o  <= '0;
      sc_offset_o <= '0;
      sc_bias_o   <= '0;
    end else if (acc_accept) begin
      v1_q        <= 1'b1;
      ch1_q       <= ch_q;
      last1_q     <= beat_last;
      sc_wx_o     <= acc_data_i;
      sc_scale_o  <= tbl_scale[ch_q];
      sc_shift_o  <= tbl_shift[ch_q];
      sc_offset_o <= tbl_offset[ch_q];
      sc_bias_o   <= tbl_bias[ch_q];
    end else if (adv2) begin
      v1_q        <= 1'b0;
    end
  end

  // S2: scaler result with its channel tag, presented downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q       <= 1'b0;
      out_data_o <= '0;
      out_ch_o   <= '0;
      out_last_o <= 1'b0;
    end else if (adv2) begin
      v2_q       <= 1'b1;
      out_data_o <= sc_y_i;
      out_ch_o   <= ch1_q;
      out_last_o <= last1_q;
    end else if (v2_q && out_ready_i) begin
      v2_q       <= 1'b0;
    end
  end

  // One-cycle status pulses: end of run / empty run, and rejected table write
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= start_bad | last_hs;
      err_q  <= prm_reject;
    end
  end

endmodule

// File: tb/tb_output_scaler_sequencer.sv
// Bench for output_scaler_sequencer. A stand-in scaler drives sc_y_i from the
// registered operands; a table/stream model predicts every output beat and a
// negedge monitor compares each handshake, stall hold and backpressure rule.
module tb_output_scaler_sequencer;

  localparam int NCH  = 24;               // table depth small enough to address past its end
  localparam int CHW  = $clog2(NCH) + 1;
  localparam int IDXW = CHW - 1;
  localparam int EW   = 8 + IDXW + 1;     // {data, ch, last}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  // DUT signals
  logic              start = 0;
  logic [CHW-1:0]    num_ch = '0;
  logic [15:0]       num_px = '0;
  logic              cfg_uns = 0;
  logic [3:0]        cfg_ob = '0;
  logic              busy, done;
  logic              prm_we = 0;
  logic [IDXW-1:0]   prm_addr = '0;
  logic [15:0]       prm_scale = '0, prm_shift = '0;
  logic [7:0]        prm_off = '0;
  logic [31:0]       prm_bias = '0;
  logic              prm_err;
  logic              acc_valid = 0;
  logic              acc_ready;
  logic signed [19:0] acc_data = '0;
  logic signed [19:0] sc_wx;
  logic [15:0]       sc_scale, sc_shift;
  logic [7:0]        sc_off;
  logic [31:0]       sc_bias;
  logic              sc_uns;
  logic [3:0]        sc_ob;
  logic [7:0]        sc_y;
  logic              out_valid;
  logic              out_ready = 1;
  logic [7:0]        out_data;
  logic [IDXW-1:0]   out_ch;
  logic              out_last;
  logic [1:0]        dbg_state;

  output_scaler_sequencer #(.NUM_CH_MAX(NCH)) dut (
    .clk(clk), .rst(rst),
    .start_i(start), .num_ch_i(num_ch), .num_px_i(num_px),
    .cfg_unsigned_i(cfg_uns), .cfg_obits_i(cfg_ob),
    .busy_o(busy), .done_o(done),
    .prm_we_i(prm_we), .prm_addr_i(prm_addr), .prm_scale_i(prm_scale),
    .prm_shift_i(prm_shift), .prm_offset_i(prm_off), .prm_bias_i(prm_bias),
    .prm_err_o(prm_err),
    .acc_valid_i(acc_valid), .acc_ready_o(acc_ready), .acc_data_i(acc_data),
    .sc_wx_o(sc_wx), .sc_scale_o(sc_scale), .sc_shift_o(sc_shift),
    .sc_offset_o(sc_off), .sc_bias_o(sc_bias),
    .sc_unsigned_o(sc_uns), .sc_output_bits_o(sc_ob), .sc_y_i(sc_y),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_last_o(out_last),
    .dbg_state_o(dbg_state)
  );

  // Scaler arithmetic: y = sat(((wx*scale)>>16 >> shift) + bias + offset)
  function automatic logic [7:0] scale_fn(input logic signed [19:0] wx, input logic [15:0] sc,
                                          input logic [15:0] sh, input logic [7:0] off,
                                          input logic [31:0] bias, input logic uns,
                                          input logic [3:0] ob);
    longint p, lo, hi;
    p = longint'(wx) * longint'({1'b0, sc});
    p = p >>> 16;
    p = p >>> sh[4:0];
    p = p + longint'($signed(bias)) + longint'($signed(off));
    if (ob == 4'd0) return 8'd0;
    if (uns) begin
      lo = 0;
      hi = (64'sd1 <<< ob) - 1;
    end else begin
      lo = -(64'sd1 <<< (ob - 1));
      hi = (64'sd1 <<< (ob - 1)) - 1;
    end
    if (p < lo) p = lo;
    if (p > hi) p = hi;
    return p[7:0];
  endfunction

  // external scaler stand-in
  always_comb sc_y = scale_fn(sc_wx, sc_scale, sc_shift, sc_off, sc_bias, sc_uns, sc_ob);

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [7:0]    got_q[$];
  int            acc_q[$];
  logic [15:0]   m_scale[NCH];
  logic [15:0]   m_shift[NCH];
  logic [7:0]    m_off[NCH];
  logic [31:0]   m_bias[NCH];
  int checks = 0, passes = 0;
  int acc_cnt = 0, out_cnt = 0, stall_cnt = 0;
  int ready_mode = 0, cyc = 0;
  bit prev_stall = 0;
  logic [EW-1:0] prev_word = '0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) begin
      m_scale[i] = '0; m_shift[i] = '0; m_off[i] = '0; m_bias[i] = '0;
    end
  endtask

  // expected beats of a run over the stream in acc_q
  task automatic build_exp(input int nch, input int npx, input logic uns, input logic [3:0] ob);
    int total, c, tmp;
    logic signed [19:0] w;
    logic [7:0] y;
    logic [IDXW-1:0] cc;
    total = nch * npx;
    for (int k = 0; k < total; k++) begin
      c   = k % nch;
      tmp = acc_q[k];
      w   = 20'(tmp);
      y   = scale_fn(w, m_scale[c], m_shift[c], m_off[c], m_bias[c], uns, ob);
      cc  = IDXW'(c);
      exp_q.push_back({y, cc, (k == total - 1)});
    end
  endtask

  task automatic fill_formula(input int n, input int seed);
    acc_q.delete();
    for (int k = 0; k < n; k++) acc_q.push_back(((k * 7919 + seed) % 401) - 200);
  endtask

  // ready pattern: always ready, or ready one cycle in three
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  task automatic do_reset();
    rst = 1; start = 0; acc_valid = 0; prm_we = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic write_prm(input int addr, input logic [15:0] sc, input logic [15:0] sh,
                           input logic [7:0] off, input logic [31:0] bias,
                           input bit exp_err, input string name);
    @(posedge clk); #1;
    prm_we = 1; prm_addr = IDXW'(addr);
    prm_scale = sc; prm_shift = sh; prm_off = off; prm_bias = bias;
    @(posedge clk); #1;
    prm_we = 0;
    @(negedge clk);
    chk(prm_err == exp_err, name, prm_err, exp_err);
    if (!exp_err) begin
      m_scale[addr] = sc; m_shift[addr] = sh; m_off[addr] = off; m_bias[addr] = bias;
    end
  endtask

  task automatic start_run(input int nch, input int npx, input logic uns, input logic [3:0] ob);
    @(posedge clk); #1;
    start = 1; num_ch = CHW'(nch); num_px = 16'(npx); cfg_uns = uns; cfg_ob = ob;
    @(posedge clk); #1;
    start = 0;
  endtask

  // offers acc_q[0..n-1] in order; a beat is taken when acc_ready is high before the edge
  task automatic feed(input int n);
    int sent, guard;
    bit taken;
    sent = 0; guard = 0;
    while (sent < n && guard < 2000) begin
      acc_valid = 1;
      acc_data  = 20'(acc_q[sent]);
      @(negedge clk);
      taken = acc_ready;
      @(posedge clk); #1;
      if (taken) sent++;
      guard++;
    end
    acc_valid = 0;
    if (sent < n) chk(0, "feed_timeout", sent, n);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(seen, {name, "_done"}, seen, 1);
    if (seen) begin
      chk(exp_q.size() == 0, {name, "_all_out"}, exp_q.size(), 0);
      chk(!busy, {name, "_idle_at_done"}, busy, 0);
      @(negedge clk);
      chk(!done, {name, "_done_one_cycle"}, done, 0);
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic bad_start(input int nch, input int npx, input string name);
    start_run(nch, npx, 1'b0, 4'd8);
    @(negedge clk);
    chk(done && !busy, {name, "_done"}, {done, busy}, 2'b10);
    @(negedge clk);
    chk(!done && !busy, {name, "_pulse"}, {done, busy}, 2'b00);
  endtask

  task automatic load_t2_table();
    write_prm(0, 16'h4000, 16'd0, 8'd0,   32'd0,          0, "wr_ch0");
    write_prm(1, 16'h8000, 16'd1, 8'd3,   32'd0,          0, "wr_ch1");
    write_prm(2, 16'hC000, 16'd0, 8'd0,   32'hFFFF_FFFB,  0, "wr_ch2");
    write_prm(3, 16'h2000, 16'd2, 8'd0,   32'd100,        0, "wr_ch3");
  endtask

  // compare process: every output handshake, stall hold, and backpressure rule
  always @(negedge clk) begin
    logic [EW-1:0] cur, e;
    if (rst) begin
      acc_cnt = 0; out_cnt = 0; prev_stall = 0;
    end else begin
      cur = {out_data, out_ch, out_last};
      if (prev_stall) chk(out_valid && cur == prev_word, "stall_hold", cur, prev_word);
      if ((acc_cnt - out_cnt) >= 2 && !out_ready) chk(!acc_ready, "ready_when_full", acc_ready, 0);
      if (busy && acc_valid && !acc_ready) stall_cnt++;
      if (acc_valid && acc_ready) acc_cnt++;
      if (out_valid && out_ready) begin
        out_cnt++;
        got_q.push_back(out_data);
        if (exp_q.size() == 0) chk(0, "unexpected_beat", cur, 0);
        else begin
          e = exp_q.pop_front();
          chk(cur == e, "beat", cur, e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    do_reset();

    // reset state
    @(negedge clk);
    chk(!busy && !done && !prm_err, "rst_status", {busy, done, prm_err}, 0);
    chk(!out_valid && !acc_ready, "rst_handshake", {out_valid, acc_ready}, 0);
    chk(out_data == 0 && out_ch == 0 && !out_last, "rst_out", {out_data, out_ch, out_last}, 0);
    chk(sc_wx == 0 && sc_scale == 0 && dbg_state == 0, "rst_s1", sc_wx, 0);

    // pin the scaler model with hand-computed values
    chk(scale_fn(20'sd100, 16'h8000, 16'd0, 8'd0, 32'd0, 1'b1, 4'd8) == 8'd50, "pin_half", 0, 50);
    chk(scale_fn(20'sd1000, 16'hFFFF, 16'd0, 8'd0, 32'd0, 1'b0, 4'd4) == 8'd7, "pin_sat_pos", 0, 7);
    chk(scale_fn(-20'sd1000, 16'hFFFF, 16'd0, 8'd0, 32'd0, 1'b0, 4'd4) == 8'hF8, "pin_sat_neg", 0, 8'hF8);

    // single beat: latency, operands, last, done
    write_prm(0, 16'h8000, 16'd0, 8'd0, 32'd0, 0, "t1_wr");
    acc_q.delete(); acc_q.push_back(100);
    build_exp(1, 1, 1'b1, 4'd8);
    got_q.delete();
    start_run(1, 1, 1'b1, 4'd8);
    acc_valid = 1; acc_data = 20'sd100;
    @(negedge clk);
    chk(acc_ready, "t1_acc_ready", acc_ready, 1);
    chk(sc_uns && sc_ob == 4'd8, "t1_cfg", {sc_uns, sc_ob}, 5'h18);
    @(posedge clk); #1;
    acc_valid = 0;
    @(negedge clk);
    chk(!out_valid && busy, "t1_s1_stage", {out_valid, busy}, 2'b01);
    chk(sc_wx == 20'sd100 && sc_scale == 16'h8000, "t1_operands", sc_wx, 100);
    @(negedge clk);
    chk(out_valid && out_last && out_data == 8'd50, "t1_s2_stage", {out_valid, out_last, out_data}, {2'b11, 8'd50});
    wait_done(20, "t1");
    chk(got_q.size() == 1 && got_q[0] == 8'd50, "t1_value", got_q.size() > 0 ? got_q[0] : 0, 50);

    // 4 channels x 3 pixels at full throughput
    load_t2_table();
    fill_formula(12, 0);
    build_exp(4, 3, 1'b0, 4'd8);
    got_q.delete();
    start_run(4, 3, 1'b0, 4'd8);
    stall_cnt = 0;
    fork
      feed(12);
      wait_done(200, "t2");
    join
    chk(stall_cnt == 0, "t2_no_bubble", stall_cnt, 0);
    chk(got_q.size() == 12, "t2_beat_count", got_q.size(), 12);

    // same run under 1-of-3 backpressure, with a rejected write mid-run
    ready_mode = 1;
    fill_formula(12, 55);
    build_exp(4, 3, 1'b0, 4'd8);
    got_q.delete();
    start_run(4, 3, 1'b0, 4'd8);
    fork
      feed(12);
      wait_done(400, "t3");
      begin
        repeat (3) @(posedge clk);
        write_prm(0, 16'h1234, 16'd3, 8'd9, 32'd77, 1, "t3_busy_write_err");
      end
    join
    chk(got_q.size() == 12, "t3_beat_count", got_q.size(), 12);
    ready_mode = 0;

    // signed 4-bit saturation
    write_prm(0, 16'hFFFF, 16'd0, 8'd0, 32'd0, 0, "t4_wr");
    acc_q.delete(); acc_q.push_back(1000); acc_q.push_back(-1000);
    build_exp(1, 2, 1'b0, 4'd4);
    got_q.delete();
    start_run(1, 2, 1'b0, 4'd4);
    fork
      feed(2);
      wait_done(50, "t4");
    join
    chk(got_q.size() == 2 && got_q[0] == 8'd7, "t4_pos", got_q.size() > 0 ? got_q[0] : 0, 7);
    chk(got_q.size() == 2 && got_q[1] == 8'hF8, "t4_neg", got_q.size() > 1 ? got_q[1] : 0, 8'hF8);

    // out-of-range write and empty/oversized starts
    write_prm(NCH, 16'h1111, 16'd1, 8'd1, 32'd1, 1, "t5_addr_err");
    bad_start(1, 0, "t5_px0");
    bad_start(0, 1, "t5_ch0");
    bad_start(NCH + 1, 1, "t5_ch_over");

    // reset after 5 of 12 beats, then clean runs
    load_t2_table();
    fill_formula(12, 3);
    build_exp(4, 3, 1'b0, 4'd8);
    start_run(4, 3, 1'b0, 4'd8);
    feed(5);
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    clear_model();
    @(negedge clk);
    chk(!busy && !out_valid && dbg_state == 0, "t6_cleared", {busy, out_valid}, 0);
    begin
      bit seen_done, seen_valid;
      seen_done = 0; seen_valid = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        seen_done  |= done;
        seen_valid |= out_valid;
      end
      chk(!seen_done && !seen_valid, "t6_quiet", {seen_done, seen_valid}, 0);
    end
    // table was cleared by reset: every result is zero
    fill_formula(2, 9);
    build_exp(2, 1, 1'b0, 4'd8);
    start_run(2, 1, 1'b0, 4'd8);
    fork
      feed(2);
      wait_done(50, "t6_zero_tbl");
    join
    load_t2_table();
    fill_formula(12, 21);
    build_exp(4, 3, 1'b0, 4'd8);
    got_q.delete();
    start_run(4, 3, 1'b0, 4'd8);
    fork
      feed(12);
      wait_done(200, "t6_rerun");
    join
    chk(got_q.size() == 12, "t6_beat_count", got_q.size(), 12);

    // table write and start in the same cycle: run sees the new entry
    m_scale[1] = 16'h8000; m_shift[1] = 16'd0; m_off[1] = 8'd0; m_bias[1] = 32'd7;
    acc_q.delete(); acc_q.push_back(40); acc_q.push_back(40);
    build_exp(2, 1, 1'b1, 4'd8);
    got_q.delete();
    @(posedge clk); #1;
    prm_we = 1; prm_addr = IDXW'(1); prm_scale = 16'h8000; prm_shift = 16'd0;
    prm_off = 8'd0; prm_bias = 32'd7;
    start = 1; num_ch = CHW'(2); num_px = 16'd1; cfg_uns = 1; cfg_ob = 4'd8;
    @(posedge clk); #1;
    prm_we = 0; start = 0;
    fork
      feed(2);
      wait_done(50, "t7");
    join
    chk(got_q.size() == 2 && got_q[1] == 8'd27, "t7_new_entry", got_q.size() > 1 ? got_q[1] : 0, 27);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
